// File: rtl/block_lock_pkg.sv
// Shared types and helpers for the 64b/66b block lock state machine.
package block_lock_pkg;

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP      = 2'd2,
    SLIP_WAIT = 2'd3
  } state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  function automatic logic sh_valid(input logic [1:0] hdr);
    return (hdr == SH_DATA) || (hdr == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_lock.sv
// 64b/66b block synchroniser: tests sync headers, requests gearbox slips
// until alignment is found and reports block lock downstream.
module block_lock
  import block_lock_pkg::*;
#(
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVLD_MAX     = 16,
  parameter int SLIP_WAIT_CYCLES = 3   // must be >= 1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_init_done,
  input  logic [1:0] i_header,
  input  logic       i_valid,
  output logic       o_slip,
  output logic       o_block_lock
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]    sh_invld_q, sh_invld_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                lock_q, lock_d;

  logic                hdr_ok;
  logic [CNT_W-1:0]    cnt_inc;
  logic [INV_W-1:0]    invld_inc;

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    sh_invld_d = sh_invld_q;
    wait_cnt_d = wait_cnt_q;
    lock_d     = lock_q;

    hdr_ok    = sh_valid(i_header);
    cnt_inc   = sh_cnt_q + CNT_W'(1);
    invld_inc = sh_invld_q + (hdr_ok ? INV_W'(0) : INV_W'(1));

    case (state_q)
      RESET_CNT: begin
        sh_cnt_d   = '0;
        sh_invld_d = '0;
        state_d    = TEST_SH;
      end
      TEST_SH: begin
        if (i_valid) begin
          sh_cnt_d   = cnt_inc;
          sh_invld_d = invld_inc;
          if (!lock_q) begin
            if (!hdr_ok) begin
              state_d = SLIP;
            end else if (cnt_inc == CNT_W'(SH_CNT_MAX)) begin
              lock_d  = 1'b1;
              state_d = RESET_CNT;
            end
          end else begin
            // Loss of lock wins over a window end on the same beat.
            if (invld_inc == INV_W'(SH_INVLD_MAX)) begin
              lock_d  = 1'b0;
              state_d = SLIP;
            end else if (cnt_inc == CNT_W'(SH_CNT_MAX)) begin
              state_d = RESET_CNT;
            end
          end
        end
      end
      SLIP: begin
        lock_d = 1'b0;
        if (i_valid) begin
          wait_cnt_d = '0;
          state_d    = SLIP_WAIT;
        end
      end
      SLIP_WAIT: begin
        if (wait_cnt_q == WAIT_W'(SLIP_WAIT_CYCLES - 1)) begin
          state_d = RESET_CNT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = RESET_CNT;
    endcase

    if (!i_init_done) begin
      state_d    = RESET_CNT;
      sh_cnt_d   = '0;
      sh_invld_d = '0;
      wait_cnt_d = '0;
      lock_d     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= RESET_CNT;
      sh_cnt_q   <= '0;
      sh_invld_q <= '0;
      wait_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_invld_q <= sh_invld_d;
      wait_cnt_q <= wait_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign o_slip       = (state_q == SLIP);
  assign o_block_lock = lock_q;

endmodule

// File: tb/tb_block_lock.sv
// Directed bench for block_lock: vector table for the slip handshake plus
// hand-written sequences for acquisition, lock tolerance and resets.
module tb_block_lock;

  logic       clk;
  logic       rst_n;
  logic       init_done;
  logic [1:0] header;
  logic       valid;
  logic       slip;
  logic       lock;

  int total = 0;
  int bad   = 0;
  logic slip_seen;

  block_lock #(
    .SH_CNT_MAX      (64),
    .SH_INVLD_MAX    (16),
    .SLIP_WAIT_CYCLES(3)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_init_done (init_done),
    .i_header    (header),
    .i_valid     (valid),
    .o_slip      (slip),
    .o_block_lock(lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] h;
    logic       exp_slip;
    logic       exp_lock;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [1:0] h, input logic es, input logic el);
    vec_t t;
    t.v = v; t.h = h; t.exp_slip = es; t.exp_lock = el;
    vecs.push_back(t);
  endtask

  // Drive one clock's inputs, then sample just after the rising edge.
  task automatic step(input logic v, input logic [1:0] h);
    valid  = v;
    header = h;
    @(posedge clk);
    #1;
    if (slip) slip_seen = 1'b1;
  endtask

  task automatic chk(input string name, input logic es, input logic el);
    total++;
    if (slip !== es || lock !== el) begin
      bad++;
      $display("FAIL %s: slip=%b lock=%b, required slip=%b lock=%b", name, slip, lock, es, el);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  // 64 valid beats from TEST_SH; invalid (2'b00) from beat index inv_from on.
  task automatic window(input string name, input int inv_from, input logic lock_before,
                        input logic es63, input logic el63, input logic el64_s, input logic el64_l);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, (i >= inv_from) ? 2'b00 : ((i % 2) ? 2'b10 : 2'b01));
      if (i == 62) chk({name, "_beat63"}, es63, el63);
    end
    chk({name, "_beat64"}, el64_s, el64_l);
    if (lock_before) begin end
  endtask

  initial begin
    rst_n     = 1'b0;
    init_done = 1'b1;
    valid     = 1'b0;
    header    = 2'b00;
    slip_seen = 1'b0;

    // Reset held with random traffic.
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      chk("reset_hold", 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    // Slip handshake table, starting in RESET_CNT.
    add(1, 2'b11, 0, 0);  // RESET_CNT clock, header ignored
    add(1, 2'b11, 1, 0);  // first invalid header -> SLIP
    add(0, 2'b01, 1, 0);
    add(0, 2'b11, 1, 0);
    add(0, 2'b00, 1, 0);
    add(0, 2'b10, 1, 0);
    add(0, 2'b11, 1, 0);  // five idle clocks hold the slip
    add(1, 2'b00, 0, 0);  // consuming clock
    add(1, 2'b11, 0, 0);  // SLIP_WAIT x3, headers ignored
    add(1, 2'b11, 0, 0);
    add(1, 2'b11, 0, 0);
    add(1, 2'b11, 0, 0);  // RESET_CNT clock
    add(1, 2'b11, 1, 0);  // evaluation resumed
    add(1, 2'b00, 0, 0);  // consume
    add(1, 2'b11, 0, 0);
    add(0, 2'b11, 0, 0);  // wait count runs without valid
    add(1, 2'b11, 0, 0);
    add(1, 2'b11, 0, 0);  // RESET_CNT -> TEST_SH
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].h);
      chk($sformatf("vec%0d", i), vecs[i].exp_slip, vecs[i].exp_lock);
    end

    // Clean acquisition from TEST_SH.
    slip_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 2'b01);
      if (i == 62) chk("acq_beat63", 1'b0, 1'b0);
    end
    chk("acq_beat64", 1'b0, 1'b1);
    chk_bit("acq_no_slip", slip_seen, 1'b0);

    // Locked window with 15 invalid headers keeps lock.
    step(1'b1, 2'b00);
    chk("winA_reset_cnt", 1'b0, 1'b1);
    window("winA", 49, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // 16th invalid header lands on the window's last beat: loss of lock wins.
    step(1'b1, 2'b01);
    chk("winB_reset_cnt", 1'b0, 1'b1);
    window("winB", 48, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Async reset while slipping, mid-cycle.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_immediate", 1'b0, 1'b0);
    step(1'b1, 2'b01);
    chk("async_rst_held", 1'b0, 1'b0);
    rst_n = 1'b1;

    // Gapped reacquisition: valid drops every 33rd clock with a bad header.
    step(1'b1, 2'b01);
    chk("gap_reset_cnt", 1'b0, 1'b0);
    begin
      int nvalid;
      nvalid = 0;
      for (int k = 1; k < 200 && nvalid < 64; k++) begin
        if (k % 33 == 0) begin
          step(1'b0, 2'b11);
        end else begin
          step(1'b1, 2'b10);
          nvalid++;
          if (nvalid == 63) chk("gap_beat63", 1'b0, 1'b0);
        end
      end
      chk_bit("gap_beat_count", (nvalid == 64), 1'b1);
    end
    chk("gap_beat64", 1'b0, 1'b1);

    // init_done low acts as synchronous reset.
    init_done = 1'b0;
    step(1'b1, 2'b01);
    chk("init_low_1", 1'b0, 1'b0);
    step(1'b1, 2'b11);
    chk("init_low_2", 1'b0, 1'b0);
    init_done = 1'b1;
    step(1'b1, 2'b01);
    chk("init_reset_cnt", 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, (i % 2) ? 2'b01 : 2'b10);
      if (i == 62) chk("init_beat63", 1'b0, 1'b0);
    end
    chk("init_beat64", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
